// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out of the fetch unit,
// acknowledge/read data back from memory.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Architectural PC owner: fetches one instruction per request/ack handshake,
// hands it to decode, waits for stall release, and halts on misaligned PCs.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC          = 32'h0000_3000,
  parameter int unsigned RESET_HOLD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            next_pc,
  input  logic                   stall,
  output logic [31:0]            curr_pc,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            instr,
  output logic                   instr_valid,
  output logic                   exc_adel,
  output logic                   halted,
  output logic [31:0]            fetch_count
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_REQ,
    S_ISSUED,
    S_HALT
  } state_e;

  localparam logic [3:0] HOLD_INIT = 4'(RESET_HOLD_CYCLES);

  state_e      state_q;
  logic [3:0]  hold_cnt_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic        exc_adel_q;
  logic        halted_q;
  logic [31:0] fetch_count_q;
  logic [31:0] fetch_count_d;
  logic        pc_aligned;

  assign pc_aligned    = (pc_q[1:0] == 2'b00);
  assign fetch_count_d = fetch_count_q + 32'd1;

  // NOTE: every register below is updated with <= so all of them see the
  // pre-edge values of each other, exactly like the flops they become.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_HOLD;
      hold_cnt_q    <= HOLD_INIT;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      exc_adel_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_cnt_q == 4'd0) begin
            state_q <= S_REQ;
          end else begin
            hold_cnt_q <= hold_cnt_q - 4'd1;
          end
        end
        S_REQ: begin
          // A misaligned PC never reaches the bus; it traps on the next edge.
          if (!pc_aligned) begin
            exc_adel_q <= 1'b1;
            halted_q   <= 1'b1;
            state_q    <= S_HALT;
          end else if (imem.imem_ack) begin
            instr_q       <= imem.imem_rdata;
            instr_valid_q <= 1'b1;
            fetch_count_q <= fetch_count_d;
            state_q       <= S_ISSUED;
          end
        end
        S_ISSUED: begin
          if (!stall) begin
            pc_q          <= next_pc;
            instr_valid_q <= 1'b0;
            state_q       <= S_REQ;
          end
        end
        S_HALT: begin
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Request is decoded from state so an asynchronous reset drops it at once.
  assign imem.imem_req  = (state_q == S_REQ) && pc_aligned;
  assign imem.imem_addr = pc_q;

  assign curr_pc     = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign exc_adel    = exc_adel_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the architectural PC register and drives instruction fetch.
- Sends `curr_pc` to the next-PC logic and takes its `next_pc` result back: it is the consumer/feedback end of that path.
- Runs a request/acknowledge handshake with instruction memory, presents the fetched word to decode, honours pipeline stall, and halts on misaligned fetch addresses.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- RESET_HOLD_CYCLES, 2, idle cycles after reset release before first fetch; range 0..15.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- next_pc  input  32  next PC computed from `curr_pc` and the current instruction.
- stall  input  1  hold current instruction; block PC update.
- curr_pc  output  32  architectural PC of the instruction in `instr`.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; always equals `curr_pc`.
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  32  fetched word, valid when `imem_ack`=1.
- instr  output  32  registered instruction word.
- instr_valid  output  1  `instr` is valid for decode.
- exc_adel  output  1  sticky misaligned-fetch exception.
- halted  output  1  block is in HALT.
- fetch_count  output  32  number of completed fetches, wraps modulo 2^32.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is asynchronous and active-high; asserting it forces all state immediately, with no clock edge needed.
- Reset values:
  - `curr_pc`=RESET_PC; `instr`=0.
  - `instr_valid`=0, `imem_req`=0, `exc_adel`=0, `halted`=0.
  - `fetch_count`=0.
  - state=HOLD; hold counter=RESET_HOLD_CYCLES.
- HOLD:
  - Counter decrements each clk edge.
  - Counter==0 -> REQ on the next edge; with RESET_HOLD_CYCLES=0, REQ follows one edge after reset release.
  - `imem_ack` is ignored.
- REQ, aligned PC (`curr_pc[1:0]`==0):
  - `imem_req`=1 combinationally; `imem_addr` is stable until ack.
  - On an edge with `imem_ack`=1: `instr`<=`imem_rdata`, `instr_valid`<=1, `fetch_count`<=`fetch_count`+1, state->ISSUED.
  - No ack: remain in REQ, no timeout.
- REQ, misaligned PC (`curr_pc[1:0]`!=0):
  - `imem_req` is forced to 0.
  - Next edge: `exc_adel`<=1, state->HALT.
- ISSUED:
  - `imem_req`=0; `instr_valid`=1.
  - `stall`=1: hold `instr` and `curr_pc` unchanged.
  - `stall`=0 at an edge: `curr_pc`<=`next_pc`, `instr_valid`<=0, state->REQ.
  - `next_pc` is sampled only here; it is a don't-care in every other state.
- HALT:
  - `halted`=1, `imem_req`=0, `instr_valid`=0.
  - `curr_pc` is frozen at the faulting address; `exc_adel` stays 1.
  - Exit only via reset.
- Latency with a zero-wait memory:
  - Ack at edge t -> `instr_valid`=1 after t.
  - PC update at edge t+1 (if no stall).
  - Next `imem_req` visible after t+1.
  - Steady state: one instruction per 2 cycles.
- Ack outside REQ is ignored and does not affect `instr` or `fetch_count`.
- `stall` in HOLD or REQ has no effect; a stall only blocks the ISSUED->REQ transition.
- Wrap-around: `next_pc` is taken verbatim. 32'hFFFF_FFFC -> 32'h0000_0000 is legal; there is no internal +4.
- `fetch_count` wraps from 32'hFFFF_FFFF to 0 without a flag.
- Reset mid-operation, including with `imem_req`=1 outstanding:
  - The request is abandoned and `imem_req` drops asynchronously.
  - A late ack during HOLD is dropped.
- No X may propagate to outputs after reset.

Test Plan:
- Reset sequence: reset 3 cycles, release, memory acks immediately with 32'h2408_0001 -> `imem_req` first rises exactly RESET_HOLD_CYCLES+1 edges after release with `imem_addr`=32'h0000_3000; `instr`=32'h2408_0001, `instr_valid`=1, `fetch_count`=1.
- Sequential fetch: `next_pc`=`curr_pc`+4, memory acks after 2 wait cycles, 4 instructions -> addresses 0x3000, 0x3004, 0x3008, 0x300C in order; `fetch_count`=4; `imem_addr` stable throughout each wait.
- Stall: assert `stall` for 5 cycles while ISSUED at PC 0x3008 -> `curr_pc` and `instr` unchanged, no `imem_req`; first edge after `stall`=0 loads `next_pc`=0x3040 and requests 0x3040.
- Misaligned jump: `next_pc`=32'h0000_3042 -> `imem_req` never asserted for 0x3042; `exc_adel`=1 and `halted`=1 one edge later; state unchanged after 20 further cycles; ack pulses ignored.
- Reset mid-request: reset asserted while `imem_req`=1 at 0x3010, memory acks one cycle after reset release -> `imem_req` drops without clock edge, ack ignored, `fetch_count`=0, `curr_pc`=0x3000.
- Wrap: `next_pc`=32'hFFFF_FFFC then 32'h0000_0000; preload `fetch_count` near 32'hFFFF_FFFF via forced state -> addresses fetched 0xFFFF_FFFC, 0x0000_0000; `fetch_count` wraps to 0.
